bram_stream_reader: RTL and testbench

- Read-side master that sits directly upstream of the block RAM.
- Accepts a burst command (start address, beat count), issues sequential single-cycle reads into the RAM read port, and absorbs the RAM's 1-cycle read latency.
- Delivers the data as a valid/ready stream with a last-beat marker.
- A small credit-controlled FIFO guarantees no read data is lost under downstream backpressure.

---
 rtl/bram_pkg.sv | 18 +
 rtl/bram_stream_reader_if.sv | 39 +++
 rtl/bram_sfifo.sv | 54 +++++
 rtl/bram_stream_reader.sv | 146 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// Shared types and default sizes for the BRAM stream reader slice.
//   rd_state_e : reader FSM states (IDLE, READ, DRAIN)
//   ALEN_D     : default RAM address width
//   DLEN_D     : default RAM data width
//   LENW_D     : default burst length field width (cmd_len = beats - 1)
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int ALEN_D = 10;
  localparam int DLEN_D = 32;
  localparam int LENW_D = 8;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: burst command, RAM read port and
// output stream.
//   master : the reader (takes commands, drives RAM reads, sources stream)
//   slave  : the environment (command source, RAM, stream consumer)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command (len = beats - 1)
//   mem_ren/mem_raddr                    : RAM read request
//   mem_rvalid/mem_rdata                 : RAM read return, 1 cycle later
//   m_valid/m_ready/m_data/m_last        : output stream
interface bram_stream_reader_if
  import bram_pkg::*;
#(
  parameter int ALEN = ALEN_D,
  parameter int DLEN = DLEN_D,
  parameter int LENW = LENW_D
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ALEN-1:0] cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic            mem_ren;
  logic [ALEN-1:0] mem_raddr;
  logic            mem_rvalid;
  logic [DLEN-1:0] mem_rdata;
  logic            m_valid;
  logic            m_ready;
  logic [DLEN-1:0] m_data;
  logic            m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rvalid, mem_rdata, m_ready,
    output cmd_ready, mem_ren, mem_raddr, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rvalid, mem_rdata, m_ready,
    input  cmd_ready, mem_ren, mem_raddr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bram_sfifo.sv
// Small synchronous FIFO used as the reader's output buffer.
// Head data is read combinationally from storage.
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   push, wdata    : write side
//   pop, rdata     : read side (pop ignored when empty)
//   count          : occupancy 0..DEPTH
//   empty, full    : status
// DEPTH must be a power of two so the pointers wrap naturally.
module bram_sfifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             pop_en;

  assign pop_en = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign rdata  = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= wp + 1'b1;
      if (pop_en) rp <= rp + 1'b1;
      case ({push, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Burst read master in front of a block RAM. Accepts (addr, len) bursts,
// issues one read per cycle, absorbs the RAM's 1-cycle latency and streams
// the data out as valid/ready with a last-beat marker.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   bus        : bram_stream_reader_if.master (command, RAM port, stream)
//   perf_beats : stream handshake count        (BRAM_RD_PERF_EN only)
//   perf_stall : READ cycles blocked by credit  (BRAM_RD_PERF_EN only)
// Optional macro: BRAM_RD_PERF_EN adds the two performance counters.
// Interface parameters must match ALEN/DLEN/LENW here.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int ALEN       = ALEN_D,
  parameter int DLEN       = DLEN_D,
  parameter int LENW       = LENW_D,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  bram_stream_reader_if.master    bus
`ifdef BRAM_RD_PERF_EN
  ,
  output logic [31:0]             perf_beats,
  output logic [31:0]             perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e       state, state_nx;
  logic [ALEN-1:0] addr, addr_nx;
  logic [LENW-1:0] rem, rem_nx;

  logic            issue, issue_last;
  logic [ALEN-1:0] issue_addr;

  // Read pipeline: [0] read on the RAM port this cycle (== mem_ren),
  // [1] its data is on mem_rdata this cycle (the inflight flag).
  logic [1:0]      vld_pipe, last_pipe;

  logic            push, pop, empty, full;
  logic [CW-1:0]   count;
  logic [DLEN:0]   head;
  logic [CW:0]     outstanding;
  logic            credit_ok;

  // Credit covers both pipeline stages: at full rate one read is on the RAM
  // port while the previous one's data is returning, and both land in the
  // FIFO before a read issued now does.
  assign outstanding = (CW+1)'(count) + (CW+1)'(vld_pipe[0]) + (CW+1)'(vld_pipe[1]);
  assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);

  // The first read issues on the command handshake itself so mem_ren
  // appears the very next cycle; addr/rem then track the following read.
  always_comb begin
    state_nx      = state;
    addr_nx       = addr;
    rem_nx        = rem;
    issue         = 1'b0;
    issue_last    = 1'b0;
    issue_addr    = addr;
    bus.cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          issue      = 1'b1;
          issue_addr = bus.cmd_addr;
          issue_last = (bus.cmd_len == '0);
          addr_nx    = bus.cmd_addr + 1'b1;
          rem_nx     = bus.cmd_len - 1'b1;
          state_nx   = (bus.cmd_len == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem == '0);
          addr_nx    = addr + 1'b1;
          rem_nx     = rem - 1'b1;
          if (rem == '0) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_pipe == 2'b00 && (empty || (count == CW'(1) && pop)))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      vld_pipe      <= '0;
      last_pipe     <= '0;
      bus.mem_raddr <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      rem       <= rem_nx;
      vld_pipe  <= {vld_pipe[0], issue};
      last_pipe <= {last_pipe[0], issue_last};
      if (issue) bus.mem_raddr <= issue_addr;
    end
  end

  assign bus.mem_ren = vld_pipe[0];

  // Returns with no read outstanding (e.g. right after reset) are dropped.
  assign push = bus.mem_rvalid && vld_pipe[1];
  assign pop  = !empty && bus.m_ready;

  bram_sfifo #(.WIDTH(DLEN + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({last_pipe[1], bus.mem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Stale storage is masked so the stream reads zero while empty.
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? '0 : head[DLEN-1:0];
  assign bus.m_last  = !empty && head[DLEN];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

`ifdef BRAM_RD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (pop)                        perf_beats <= perf_beats + 1'b1;
      if (state == READ && !credit_ok) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader. Cycle 0 is the command handshake
// cycle; inputs change 1ns after posedge, outputs are sampled at negedge.
// RAM word at address a is {16'hCAFE, 6'b0, a}.
module tb_bram_stream_reader;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.ALEN(10), .DLEN(32), .LENW(8)) bus();

`ifdef BRAM_RD_PERF_EN
  logic [31:0] perf_beats, perf_stall;
`endif

  bram_stream_reader #(.ALEN(10), .DLEN(32), .LENW(8), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef BRAM_RD_PERF_EN
    ,
    .perf_beats (perf_beats),
    .perf_stall (perf_stall)
`endif
  );

  function automatic logic [31:0] ram(input logic [9:0] a);
    return {16'hCAFE, 6'h00, a};
  endfunction

  // RAM: one-cycle read latency
  always @(posedge clk) begin
    bus.mem_rvalid <= bus.mem_ren;
    bus.mem_rdata  <= ram(bus.mem_raddr);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Returns 1ns into cycle 1 (handshake at the end of cycle 0).
  task automatic send_cmd(input logic [9:0] a, input logic [7:0] l);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
    end
    next_cyc();
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] base;
    logic [9:0] exp_a [4];
    int nb, na, nren, stall_ren, post;
    bit stable_ok;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_m_valid",   32'(bus.m_valid),   32'd0);
    chk("rst_mem_ren",   32'(bus.mem_ren),   32'd0);
    chk("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    chk("rst_m_data",    bus.m_data,         32'd0);
    chk("rst_m_last",    32'(bus.m_last),    32'd0);
    next_cyc();

    // Single beat
    send_cmd(10'h010, 8'd0);
    @(negedge clk);  // cycle 1
    chk("t1_ren_c1",   32'(bus.mem_ren),   32'd1);
    chk("t1_raddr_c1", 32'(bus.mem_raddr), 32'h010);
    chk("t1_rdy_c1",   32'(bus.cmd_ready), 32'd0);
    @(negedge clk);  // cycle 2
    chk("t1_ren_c2",   32'(bus.mem_ren),   32'd0);
    chk("t1_mval_c2",  32'(bus.m_valid),   32'd0);
    @(negedge clk);  // cycle 3
    chk("t1_mval_c3",  32'(bus.m_valid),   32'd1);
    chk("t1_data_c3",  bus.m_data,         32'hCAFE0010);
    chk("t1_last_c3",  32'(bus.m_last),    32'd1);
    @(negedge clk);  // cycle 4
    chk("t1_rdy_c4",   32'(bus.cmd_ready), 32'd1);
    chk("t1_mval_c4",  32'(bus.m_valid),   32'd0);
    next_cyc();

    // Full-rate burst of 16
    base = 10'h100;
    nb = 0;
    send_cmd(base, 8'd15);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        chk("t2_data", bus.m_data, ram(10'(base + nb)));
        chk("t2_last", 32'(bus.m_last), 32'(nb == 15));
        chk("t2_cyc",  32'(c), 32'(3 + nb));
        nb++;
      end
      next_cyc();
    end
    chk("t2_nbeats", 32'(nb), 32'd16);

    // Backpressure: m_ready low in cycles 3..12
    do_reset();
    base = 10'h200;
    nb = 0; nren = 0; stall_ren = 0; stable_ok = 1'b1;
    send_cmd(base, 8'd9);
    for (int c = 1; c <= 30; c++) begin
      bus.m_ready = !(c >= 3 && c <= 12);
      @(negedge clk);
      if (c == 6) chk("t3_fifo_count", 32'(dut.u_fifo.count), 32'd4);
      if (bus.mem_ren) begin
        nren++;
        if (c >= 5 && c <= 14) stall_ren++;
      end
      if (c >= 3 && c <= 12 && (!bus.m_valid || bus.m_data !== ram(base)))
        stable_ok = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        chk("t3_data", bus.m_data, ram(10'(base + nb)));
        chk("t3_last", 32'(bus.m_last), 32'(nb == 9));
        chk("t3_cyc",  32'(c), 32'(13 + nb));
        nb++;
      end
      next_cyc();
    end
    bus.m_ready = 1'b1;
    chk("t3_nbeats",    32'(nb),        32'd10);
    chk("t3_nreads",    32'(nren),      32'd10);
    chk("t3_stall_ren", 32'(stall_ren), 32'd0);
    chk("t3_stable",    32'(stable_ok), 32'd1);
`ifdef BRAM_RD_PERF_EN
    @(negedge clk);
    chk("perf_beats", perf_beats, 32'd10);
    chk("perf_stall", perf_stall, 32'd10);
    next_cyc();
`endif

    // Address wrap
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    na = 0; nb = 0;
    send_cmd(10'h3FE, 8'd3);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.mem_ren) begin
        if (na < 4) chk("t4_raddr", 32'(bus.mem_raddr), 32'(exp_a[na]));
        na++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (nb < 4) chk("t4_data", bus.m_data, ram(exp_a[nb]));
        chk("t4_last", 32'(bus.m_last), 32'(nb == 3));
        nb++;
      end
      next_cyc();
    end
    chk("t4_nreads", 32'(na), 32'd4);
    chk("t4_nbeats", 32'(nb), 32'd4);

    // Reset during beat 5 (cycle 7) of a 16-beat burst
    post = 0;
    send_cmd(10'h040, 8'd15);
    for (int c = 1; c <= 20; c++) begin
      if (c == 7) rstn = 1'b0;
      if (c == 8) rstn = 1'b1;
      @(negedge clk);
      if (c == 8) begin
        chk("t5_mval_after_rst", 32'(bus.m_valid),   32'd0);
        chk("t5_rdy_after_rst",  32'(bus.cmd_ready), 32'd1);
        chk("t5_ren_after_rst",  32'(bus.mem_ren),   32'd0);
      end
      if (c >= 8 && bus.m_valid) post++;
      next_cyc();
    end
    chk("t5_no_stale_beats", 32'(post), 32'd0);
    nb = 0;
    send_cmd(10'h055, 8'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        chk("t5_data", bus.m_data, 32'hCAFE0055);
        chk("t5_last", 32'(bus.m_last), 32'd1);
        nb++;
      end
      next_cyc();
    end
    chk("t5_nbeats", 32'(nb), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
